// File: rtl/mdu_pkg.sv
// Shared definitions for the E-stage multiply/divide unit.
//   md_op_e     : 4-bit operation codes carried on e_mdu.op
//   mdu_state_e : IDLE/RUN sequencing state
//   acc_mode_e  : how the shadow product combines with HI/LO at commit
//   is_md_op()  : true for every op that touches HI/LO; the stall
//                 controller uses it to freeze D-stage MD-class instructions.
package mdu_pkg;

    typedef enum logic [3:0] {
        OpNone  = 4'd0,
        OpMult  = 4'd1,
        OpMultu = 4'd2,
        OpDiv   = 4'd3,
        OpDivu  = 4'd4,
        OpMthi  = 4'd5,
        OpMtlo  = 4'd6,
        OpMadd  = 4'd7,
        OpMaddu = 4'd8,
        OpMsub  = 4'd9,
        OpMsubu = 4'd10
    } md_op_e;

    typedef enum logic {
        StIdle = 1'b0,
        StRun  = 1'b1
    } mdu_state_e;

    typedef enum logic [1:0] {
        AccNone = 2'd0,
        AccAdd  = 2'd1,
        AccSub  = 2'd2
    } acc_mode_e;

    // MADD-class codes are included even when the accumulate feature is not
    // built; stalling on them is then merely conservative.
    function automatic logic is_md_op(input logic [3:0] op);
        return (op >= 4'(OpMult)) && (op <= 4'(OpMsubu));
    endfunction

endpackage

// File: rtl/mdu_lat_ctr.sv
// Latency sequencer for e_mdu: a loadable down-counter with an IDLE/RUN FSM.
//   clk, reset (async, active-low)
//   load      : in IDLE, load load_val and enter RUN
//   load_val  : number of busy cycles (must be >= 1)
//   busy      : high while in RUN
//   term      : high in the last RUN cycle; the owner commits on that edge
module mdu_lat_ctr
    import mdu_pkg::*;
#(
    parameter int unsigned CNT_W = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    output logic             busy,
    output logic             term
);

    localparam logic [CNT_W-1:0] CntOne = CNT_W'(1);

    mdu_state_e       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= StIdle;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        term    = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (load) begin
                    cnt_d   = load_val;
                    state_d = StRun;
                end
            end
            StRun: begin
                if (cnt_q == CntOne) begin
                    term    = 1'b1;
                    cnt_d   = '0;
                    state_d = StIdle;
                end else begin
                    cnt_d = cnt_q - CntOne;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    assign busy = (state_q == StRun);

endmodule

// File: rtl/e_mdu.sv
// Multi-cycle multiply/divide unit with private HI/LO registers, placed beside
// the E-stage ALU. One operation is accepted per start pulse while idle; the
// result is computed at acceptance into a shadow register and committed to
// HI/LO after MULT_CYCLES or DIV_CYCLES busy cycles, with a one-cycle done.
// MTHI/MTLO write immediately. start while busy is ignored.
//
// Optional feature: define MDU_MADD_EN to accept MADD/MADDU/MSUB/MSUBU, which
// add/subtract the product to/from {hi,lo} as held at the commit edge.
// Without it those codes act as NONE.
//
// Ports:
//   clk, reset (async, active-low)
//   start, op[3:0], a, b : request strobe, operation code, operands
//   busy                 : operation in flight
//   done                 : one-cycle pulse when HI/LO commit
//   hi, lo               : architectural HI/LO registers
module e_mdu
    import mdu_pkg::*;
#(
    parameter int unsigned WIDTH       = 32,
    parameter int unsigned MULT_CYCLES = 5,
    parameter int unsigned DIV_CYCLES  = 10
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [3:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int unsigned MaxLat = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int unsigned CntW   = $clog2(MaxLat + 1);

    md_op_e             op_e;
    logic               long_op, div_op, op_signed;
    logic [CntW-1:0]    lat;
    logic               ctr_load, ctr_busy, ctr_term;

    logic [2*WIDTH-1:0] mul_a, mul_b, prod;
    logic               a_neg, b_neg;
    logic [WIDTH-1:0]   a_mag, b_mag, den, q_mag, r_mag, quo, rem;
    logic [2*WIDTH-1:0] div_res, shadow_d, shadow_q;

    logic [WIDTH-1:0]   hi_q, hi_d, lo_q, lo_d;
    logic               done_q;

`ifdef MDU_MADD_EN
    acc_mode_e          acc_mode, acc_q;
`endif

    assign op_e = md_op_e'(op);

    // Operation decode.
    always_comb begin
        long_op   = 1'b0;
        div_op    = 1'b0;
        op_signed = 1'b0;
`ifdef MDU_MADD_EN
        acc_mode  = AccNone;
`endif
        case (op_e)
            OpMult:  begin long_op = 1'b1; op_signed = 1'b1; end
            OpMultu: begin long_op = 1'b1; end
            OpDiv:   begin long_op = 1'b1; div_op = 1'b1; op_signed = 1'b1; end
            OpDivu:  begin long_op = 1'b1; div_op = 1'b1; end
`ifdef MDU_MADD_EN
            OpMadd:  begin long_op = 1'b1; op_signed = 1'b1; acc_mode = AccAdd; end
            OpMaddu: begin long_op = 1'b1; acc_mode = AccAdd; end
            OpMsub:  begin long_op = 1'b1; op_signed = 1'b1; acc_mode = AccSub; end
            OpMsubu: begin long_op = 1'b1; acc_mode = AccSub; end
`endif
            default: ;
        endcase
    end

    // Multiply: extend both operands to 2*WIDTH; the low 2*WIDTH bits of the
    // product are correct for both signed and unsigned interpretations.
    always_comb begin
        mul_a = op_signed ? {{WIDTH{a[WIDTH-1]}}, a} : {{WIDTH{1'b0}}, a};
        mul_b = op_signed ? {{WIDTH{b[WIDTH-1]}}, b} : {{WIDTH{1'b0}}, b};
        prod  = mul_a * mul_b;
    end

    // Divide on magnitudes, then restore signs: quotient truncates toward zero,
    // remainder follows the dividend. min / -1 falls out naturally: the
    // magnitude of min is itself, both signs cancel, giving lo = min, hi = 0.
    always_comb begin
        a_neg = op_signed & a[WIDTH-1];
        b_neg = op_signed & b[WIDTH-1];
        a_mag = a_neg ? -a : a;
        b_mag = b_neg ? -b : b;
        // Substitute divisor keeps the divider defined; result is overridden.
        den   = (b == '0) ? {{(WIDTH-1){1'b0}}, 1'b1} : b_mag;
        q_mag = a_mag / den;
        r_mag = a_mag % den;
        quo   = (a_neg ^ b_neg) ? -q_mag : q_mag;
        rem   = a_neg ? -r_mag : r_mag;
        if (b == '0) begin
            div_res = {a, {WIDTH{1'b1}}};
        end else begin
            div_res = {rem, quo};
        end
    end

    assign shadow_d = div_op ? div_res : prod;

    assign ctr_load = start & ~ctr_busy & long_op;
    assign lat      = div_op ? CntW'(DIV_CYCLES) : CntW'(MULT_CYCLES);

    mdu_lat_ctr #(
        .CNT_W (CntW)
    ) u_lat_ctr (
        .clk      (clk),
        .reset    (reset),
        .load     (ctr_load),
        .load_val (lat),
        .busy     (ctr_busy),
        .term     (ctr_term)
    );

    // HI/LO next state: commit at the terminal edge, else immediate moves.
    always_comb begin
        hi_d = hi_q;
        lo_d = lo_q;
        if (ctr_term) begin
`ifdef MDU_MADD_EN
            case (acc_q)
                AccAdd:  {hi_d, lo_d} = {hi_q, lo_q} + shadow_q;
                AccSub:  {hi_d, lo_d} = {hi_q, lo_q} - shadow_q;
                default: {hi_d, lo_d} = shadow_q;
            endcase
`else
            {hi_d, lo_d} = shadow_q;
`endif
        end else if (start && !ctr_busy) begin
            if (op_e == OpMthi) hi_d = a;
            if (op_e == OpMtlo) lo_d = a;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            shadow_q <= '0;
            hi_q     <= '0;
            lo_q     <= '0;
            done_q   <= 1'b0;
        end else begin
            if (ctr_load) shadow_q <= shadow_d;
            hi_q   <= hi_d;
            lo_q   <= lo_d;
            done_q <= ctr_term;
        end
    end

`ifdef MDU_MADD_EN
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            acc_q <= AccNone;
        end else if (ctr_load) begin
            acc_q <= acc_mode;
        end
    end
`endif

    assign busy = ctr_busy;
    assign done = done_q;
    assign hi   = hi_q;
    assign lo   = lo_q;

endmodule

// File: tb/tb_e_mdu.sv
// Self-checking bench for e_mdu with default parameters (32-bit, 5/10 cycles).
module tb_e_mdu;
    import mdu_pkg::*;

    logic        clk;
    logic        reset;
    logic        start;
    logic [3:0]  op;
    logic [31:0] a, b;
    logic        busy, done;
    logic [31:0] hi, lo;

    int checks = 0;
    int errors = 0;

    e_mdu #(
        .WIDTH       (32),
        .MULT_CYCLES (5),
        .DIV_CYCLES  (10)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .start (start),
        .op    (op),
        .a     (a),
        .b     (b),
        .busy  (busy),
        .done  (done),
        .hi    (hi),
        .lo    (lo)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [3:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        int          cyc;
        logic [31:0] hi;
        logic [31:0] lo;
    } vec_t;

    vec_t vecs [12];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Called at a negedge; drives start for one cycle, counts busy cycles and
    // returns at the negedge where done is expected (so the next call is
    // back-to-back with this commit).
    task automatic run_vec(input string name, input logic [3:0] op_v, input logic [31:0] a_v,
                           input logic [31:0] b_v, input int exp_cyc,
                           input logic [31:0] exp_hi, input logic [31:0] exp_lo);
        int n;
        start = 1'b1;
        op    = op_v;
        a     = a_v;
        b     = b_v;
        @(negedge clk);
        start = 1'b0;
        op    = 4'(OpNone);
        check({name, "_done_early"}, 64'(done), 64'd0);
        n = 0;
        while (busy && n < 200) begin
            n++;
            @(negedge clk);
        end
        check({name, "_cycles"}, 64'(n), 64'(exp_cyc));
        check({name, "_done"}, 64'(done), (exp_cyc != 0) ? 64'd1 : 64'd0);
        check({name, "_hi"}, 64'(hi), 64'(exp_hi));
        check({name, "_lo"}, 64'(lo), 64'(exp_lo));
    endtask

    initial begin
        int n;

        vecs[0]  = '{4'(OpMult),  32'hFFFF_FFFD, 32'd7,        5,  32'hFFFF_FFFF, 32'hFFFF_FFEB};
        vecs[1]  = '{4'(OpDiv),   32'hFFFF_FFF9, 32'd2,        10, 32'hFFFF_FFFF, 32'hFFFF_FFFD};
        vecs[2]  = '{4'(OpDivu),  32'hFFFF_FFF9, 32'd2,        10, 32'h0000_0001, 32'h7FFF_FFFC};
        vecs[3]  = '{4'(OpDiv),   32'h8000_0000, 32'hFFFF_FFFF, 10, 32'h0000_0000, 32'h8000_0000};
        vecs[4]  = '{4'(OpDivu),  32'd5,         32'd0,        10, 32'h0000_0005, 32'hFFFF_FFFF};
        vecs[5]  = '{4'(OpDiv),   32'd7,         32'd0,        10, 32'h0000_0007, 32'hFFFF_FFFF};
        vecs[6]  = '{4'(OpMultu), 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5, 32'hFFFF_FFFE, 32'h0000_0001};
        vecs[7]  = '{4'(OpMult),  32'h8000_0000, 32'h8000_0000, 5, 32'h4000_0000, 32'h0000_0000};
        vecs[8]  = '{4'(OpDiv),   32'd7,         32'hFFFF_FFFE, 10, 32'h0000_0001, 32'hFFFF_FFFD};
        vecs[9]  = '{4'(OpMthi),  32'h0000_1234, 32'd0,        0,  32'h0000_1234, 32'hFFFF_FFFD};
        vecs[10] = '{4'(OpMtlo),  32'h0000_ABCD, 32'd0,        0,  32'h0000_1234, 32'h0000_ABCD};
        vecs[11] = '{4'(OpNone),  32'h0000_FFFF, 32'd3,        0,  32'h0000_1234, 32'h0000_ABCD};

        reset = 1'b0;
        start = 1'b0;
        op    = 4'(OpNone);
        a     = '0;
        b     = '0;
        #12;
        check("reset_busy", 64'(busy), 64'd0);
        check("reset_done", 64'(done), 64'd0);
        check("reset_hi", 64'(hi), 64'd0);
        check("reset_lo", 64'(lo), 64'd0);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);

        // Table vectors, issued back-to-back on each done cycle.
        for (int i = 0; i < 12; i++) begin
            run_vec($sformatf("v%0d", i), vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].cyc,
                    vecs[i].hi, vecs[i].lo);
        end

        // start during RUN is ignored; old HI/LO visible while busy.
        start = 1'b1;
        op    = 4'(OpMult);
        a     = 32'd2;
        b     = 32'd3;
        @(negedge clk);
        start = 1'b0;
        op    = 4'(OpNone);
        n = 0;
        while (busy && n < 200) begin
            n++;
            if (n == 2) begin
                start = 1'b1;
                op    = 4'(OpMult);
                a     = 32'd5;
                b     = 32'd5;
            end else begin
                start = 1'b0;
                op    = 4'(OpNone);
            end
            if (n == 3) begin
                check("run_old_hi", 64'(hi), 64'h1234);
                check("run_old_lo", 64'(lo), 64'hABCD);
            end
            @(negedge clk);
        end
        start = 1'b0;
        op    = 4'(OpNone);
        check("ign_cycles", 64'(n), 64'd5);
        check("ign_done", 64'(done), 64'd1);
        check("ign_hi", 64'(hi), 64'd0);
        check("ign_lo", 64'(lo), 64'd6);
        @(negedge clk);
        check("ign_done_pulse", 64'(done), 64'd0);
        check("ign_busy_after", 64'(busy), 64'd0);

        // Asynchronous reset in the fourth busy cycle of a DIV.
        start = 1'b1;
        op    = 4'(OpDiv);
        a     = 32'd100;
        b     = 32'd7;
        @(negedge clk);
        start = 1'b0;
        op    = 4'(OpNone);
        repeat (3) @(negedge clk);
        check("rst_pre_busy", 64'(busy), 64'd1);
        #1 reset = 1'b0;
        #1;
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_hi", 64'(hi), 64'd0);
        check("rst_lo", 64'(lo), 64'd0);
        check("rst_done", 64'(done), 64'd0);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        check("rst_stays_idle", 64'(busy), 64'd0);
        run_vec("post_rst_multu", 4'(OpMultu), 32'hFFFF_FFFF, 32'd2, 5, 32'h1, 32'hFFFF_FFFE);

        // Accumulate class.
        run_vec("acc_mult", 4'(OpMult), 32'd3, 32'd4, 5, 32'h0, 32'd12);
`ifdef MDU_MADD_EN
        run_vec("madd", 4'(OpMadd), 32'd2, 32'd5, 5, 32'h0, 32'd22);
        run_vec("msub", 4'(OpMsub), 32'd1, 32'd30, 5, 32'hFFFF_FFFF, 32'hFFFF_FFF8);
`else
        run_vec("madd_off", 4'(OpMadd), 32'd2, 32'd5, 0, 32'h0, 32'd12);
        run_vec("msub_off", 4'(OpMsub), 32'd1, 32'd30, 0, 32'h0, 32'd12);
`endif

        @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
